// File: rtl/cp0_intc.sv
// Coprocessor-0 and interrupt controller for the M stage of the 5-stage MIPS pipeline.
// Optional Count/Compare timer is enabled by defining CP0_TIMER_EN.
module cp0_intc #(
  parameter int          NUM_HWINT  = 6,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2022_0707
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [31:0]          vpc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code_in,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 exl_clr,
  output logic                 req,
  output logic [31:0]          epc_out,
  output logic [31:0]          handler_pc,
  output logic                 int_respond,
  output logic [2:0]           int_id
);

  logic [NUM_HWINT-1:0] sr_im_q;
  logic                 sr_exl_q;
  logic                 sr_ie_q;
  logic                 cause_bd_q;
  logic [NUM_HWINT-1:0] cause_ip_q;
  logic [4:0]           cause_exc_q;
  logic [31:0]          epc_q;

  logic [NUM_HWINT-1:0] hw_eff;
  logic [NUM_HWINT-1:0] pend;
  logic                 int_req;
  logic                 exc_req;
  logic                 take;
  logic                 wr_en;
  logic [2:0]           id_w;

`ifdef CP0_TIMER_EN
  localparam logic [NUM_HWINT-1:0] TMR_MASK = NUM_HWINT'(1) << (NUM_HWINT - 1);
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        tmr_pend_q;

  assign hw_eff = hwint | (tmr_pend_q ? TMR_MASK : '0);
`else
  assign hw_eff = hwint;
`endif

  assign pend    = hw_eff & sr_im_q;
  assign int_req = (|pend) & sr_ie_q & ~sr_exl_q;
  assign exc_req = (exc_code_in != 5'd0) & ~sr_exl_q;
  assign take    = int_req | exc_req;
  assign wr_en   = en & ~take;

  // Lowest-numbered pending line wins.
  always_comb begin
    id_w = 3'd0;
    for (int i = NUM_HWINT - 1; i >= 0; i--) begin
      if (pend[i]) id_w = 3'(i);
    end
  end

  assign req         = reset & take;
  assign int_respond = reset & int_req;
  assign int_id      = reset ? id_w : 3'd0;
  assign epc_out     = epc_q;
  assign handler_pc  = HANDLER_PC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      cause_ip_q <= hw_eff;
      if (take) begin
        sr_exl_q    <= 1'b1;
        cause_exc_q <= int_req ? 5'd0 : exc_code_in;
        cause_bd_q  <= bd_in;
        epc_q       <= {(bd_in ? (vpc[31:2] - 30'd1) : vpc[31:2]), 2'b00};
      end else if (en) begin
        case (addr)
          5'd12: begin
            sr_im_q  <= wdata[8 +: NUM_HWINT];
            sr_exl_q <= wdata[1];
            sr_ie_q  <= wdata[0];
          end
          5'd13:   cause_ip_q <= wdata[8 +: NUM_HWINT];
          5'd14:   epc_q      <= {wdata[31:2], 2'b00};
          default: ;
        endcase
      end
      // eret wins over an SR write landing in the same cycle.
      if (exl_clr) sr_exl_q <= 1'b0;
    end
  end

`ifdef CP0_TIMER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= 32'd0;
      compare_q  <= 32'hFFFF_FFFF;
      tmr_pend_q <= 1'b0;
    end else begin
      count_q <= (wr_en && addr == 5'd9) ? wdata : count_q + 32'd1;
      if (wr_en && addr == 5'd11) begin
        compare_q  <= wdata;
        tmr_pend_q <= 1'b0;
      end else if (count_q == compare_q) begin
        tmr_pend_q <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    rdata = 32'd0;
    case (addr)
      5'd12: begin
        rdata[8 +: NUM_HWINT] = sr_im_q;
        rdata[1]              = sr_exl_q;
        rdata[0]              = sr_ie_q;
      end
      5'd13: begin
        rdata[31]             = cause_bd_q;
        rdata[8 +: NUM_HWINT] = cause_ip_q;
        rdata[6:2]            = cause_exc_q;
      end
      5'd14: rdata = epc_q;
      5'd15: rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
      5'd9:  rdata = count_q;
      5'd11: rdata = compare_q;
`endif
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: word-level architectural model plus directed vectors.
module tb_cp0_intc;
  localparam int N = 6;
  localparam logic [31:0] PRID    = 32'h2022_0707;
  localparam logic [31:0] IM_MASK = 32'h0000_3F00;
  localparam logic [31:0] SR_MASK = IM_MASK | 32'h3;
  localparam logic [N-1:0] TMASK  = 6'b100000;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [4:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [31:0]   vpc;
  logic          bd_in;
  logic [4:0]    exc_code_in;
  logic [N-1:0]  hwint;
  logic          exl_clr;
  logic          req;
  logic [31:0]   epc_out;
  logic [31:0]   handler_pc;
  logic          int_respond;
  logic [2:0]    int_id;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_intc #(.NUM_HWINT(N)) dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr), .wdata(wdata), .rdata(rdata),
    .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hwint(hwint),
    .exl_clr(exl_clr), .req(req), .epc_out(epc_out), .handler_pc(handler_pc),
    .int_respond(int_respond), .int_id(int_id)
  );

  always #5 clk = ~clk;

  // Architectural model: registers held as whole 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  logic        m_tpend;
  logic [31:0] mn_sr, mn_cause, mn_epc, mn_count, mn_compare;
  logic        mn_tpend;
  logic [N-1:0] t_hw, t_pend, t_lsb;
  logic        t_int, t_exc, t_req;
  logic [2:0]  t_id;

  assign t_hw   = hwint | (m_tpend ? TMASK : '0);
  assign t_pend = t_hw & m_sr[8 +: N];
  assign t_int  = (|t_pend) && m_sr[0] && !m_sr[1];
  assign t_exc  = (exc_code_in != 5'd0) && !m_sr[1];
  assign t_req  = t_int || t_exc;

  always_comb begin
    t_lsb = t_pend & (~t_pend + 1'b1);
    t_id  = 3'd0;
    for (int k = 0; k < N; k++) if (t_lsb[k]) t_id = 3'(k);
  end

  always_comb begin
    mn_sr      = m_sr;
    mn_epc     = m_epc;
    mn_cause   = (m_cause & ~IM_MASK) | (32'(t_hw) << 8);
    mn_count   = m_count;
    mn_compare = m_compare;
    mn_tpend   = m_tpend;
`ifdef CP0_TIMER_EN
    mn_count   = m_count + 32'd1;
    mn_tpend   = m_tpend | (m_count == m_compare);
`endif
    if (t_req) begin
      mn_sr         = m_sr | 32'h2;
      mn_cause[31]  = bd_in;
      mn_cause[6:2] = t_int ? 5'd0 : exc_code_in;
      mn_epc        = (bd_in ? vpc - 32'd4 : vpc) & ~32'd3;
    end else if (en) begin
      case (addr)
        5'd12: mn_sr    = wdata & SR_MASK;
        5'd13: mn_cause = (mn_cause & ~IM_MASK) | (wdata & IM_MASK);
        5'd14: mn_epc   = wdata & ~32'd3;
`ifdef CP0_TIMER_EN
        5'd9:  mn_count = wdata;
        5'd11: begin mn_compare = wdata; mn_tpend = 1'b0; end
`endif
        default: ;
      endcase
    end
    if (exl_clr) mn_sr[1] = 1'b0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sr <= 0; m_cause <= 0; m_epc <= 0; m_count <= 0;
      m_compare <= 32'hFFFF_FFFF; m_tpend <= 1'b0;
    end else begin
      m_sr <= mn_sr; m_cause <= mn_cause; m_epc <= mn_epc; m_count <= mn_count;
      m_compare <= mn_compare; m_tpend <= mn_tpend;
    end
  end

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("req", 32'(req), 32'(t_req));
      chk("int_respond", 32'(int_respond), 32'(t_int));
      if (t_int) chk("int_id", 32'(int_id), 32'(t_id));
      chk("epc_out", epc_out, m_epc);
      chk("rdata", rdata, m_rd(addr));
      chk("handler_pc", handler_pc, 32'h0000_4180);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; addr = a; wdata = d;
    tick();
    en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; addr = 5'd0; wdata = 32'd0; vpc = 32'h1000;
    bd_in = 1'b0; exc_code_in = 5'd0; hwint = '0; exl_clr = 1'b0;
    #1;
    rd_chk("rst_sr", 5'd12, 32'd0);
    rd_chk("rst_cause", 5'd13, 32'd0);
    rd_chk("rst_epc", 5'd14, 32'd0);
    rd_chk("rst_prid", 5'd15, PRID);
    chk("rst_req", 32'(req), 32'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("no_spurious_req", 32'(req), 32'd0);

    // Interrupt on line 2
    mtc0(5'd12, 32'h0000_0401);
    hwint = 6'b000100;
    #1;
    chk("int_req", 32'(req), 32'd1);
    chk("int_resp", 32'(int_respond), 32'd1);
    chk("int_id2", 32'(int_id), 32'd2);
    tick();
    rd_chk("int_cause", 5'd13, 32'h0000_0400);
    chk("int_req_drop", 32'(req), 32'd0);
    rd_chk("int_sr_exl", 5'd12, 32'h0000_0403);
    chk("int_epc", epc_out, 32'h0000_1000);
    hwint = '0; exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    mtc0(5'd12, 32'd0);

    // Overflow exception in a delay slot
    exc_code_in = 5'd12; vpc = 32'h3008; bd_in = 1'b1;
    #1;
    chk("exc_req", 32'(req), 32'd1);
    chk("exc_resp", 32'(int_respond), 32'd0);
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0; vpc = 32'h1000;
    #1;
    chk("exc_epc", epc_out, 32'h0000_3004);
    rd_chk("exc_cause", 5'd13, 32'h8000_0030);

    // Interrupt and exception together, concurrent EPC write dropped
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    mtc0(5'd12, 32'h0000_0101);
    hwint = 6'b000001; exc_code_in = 5'd4; vpc = 32'h4000;
    en = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEE0;
    #1;
    chk("sim_req", 32'(req), 32'd1);
    chk("sim_resp", 32'(int_respond), 32'd1);
    chk("sim_id0", 32'(int_id), 32'd0);
    tick();
    en = 1'b0; exc_code_in = 5'd0; vpc = 32'h1000;
    rd_chk("sim_cause", 5'd13, 32'h0000_0100);
    chk("sim_epc", epc_out, 32'h0000_4000);

    // eret with concurrent SR write
    hwint = 6'b000100;
    en = 1'b1; addr = 5'd12; wdata = 32'h0000_0403; exl_clr = 1'b1;
    #1;
    chk("eret_no_req", 32'(req), 32'd0);
    tick();
    en = 1'b0; exl_clr = 1'b0;
    rd_chk("eret_sr", 5'd12, 32'h0000_0401);
    chk("eret_req", 32'(req), 32'd1);
    chk("eret_id", 32'(int_id), 32'd2);
    tick();
    hwint = '0;

    // Cause.IP write, then resample; EPC low bits; PRId read-only
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd_chk("ip_wr", 5'd13, 32'h0000_3F00);
    tick();
    rd_chk("ip_resample", 5'd13, 32'h0000_0000);
    mtc0(5'd14, 32'h0000_1237);
    chk("epc_wr", epc_out, 32'h0000_1234);
    mtc0(5'd15, 32'd0);
    rd_chk("prid_ro", 5'd15, PRID);
`ifndef CP0_TIMER_EN
    mtc0(5'd11, 32'd5);
    rd_chk("no_compare", 5'd11, 32'd0);
    rd_chk("no_count", 5'd9, 32'd0);
`else
    // Count/Compare timer on line N-1
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    mtc0(5'd12, 32'h0000_2001);
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd10);
    addr = 5'd9;
    for (int c = 0; c < 40 && req !== 1'b1; c++) tick();
    chk("tmr_req", 32'(req), 32'd1);
    chk("tmr_count", rdata, 32'd21);
    chk("tmr_id", 32'(int_id), 32'd5);
    tick();
    mtc0(5'd11, 32'd100);
    tick();
    addr = 5'd13;
    #1;
    chk("tmr_clr", rdata & 32'h0000_2000, 32'd0);
`endif

    // Asynchronous reset in the middle of a request
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    exc_code_in = 5'd5;
    #1;
    chk("pre_rst_req", 32'(req), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_req", 32'(req), 32'd0);
    rd_chk("async_rst_sr", 5'd12, 32'd0);
    exc_code_in = 5'd0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
